// File: rtl/dpram_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// dpram_fifo_ctrl
//   Synchronous FIFO controller for an external dual-port RAM. Owns the read
//   and write pointers, derives occupancy and status flags from them, and
//   drives the RAM write and read ports directly.
//
// Ports
//   clk, rst          clock; asynchronous active-low reset
//   clr               synchronous flush, wins over push/pop
//   push, push_data   producer write request and data
//   pop               consumer read request
//   pop_data          read data (RAM rd_data passed through)
//   pop_valid         pop_data valid, one cycle after an accepted pop
//   full, empty, almost_full, almost_empty, count   status
//   overflow, underflow   one-cycle pulses for rejected push/pop
//   wr_en, wr_addr, wr_data   RAM write port
//   rd_en, rd_addr, rd_data   RAM read port (rd_data valid 1 cycle after rd_en)
// ---------------------------------------------------------------------------
module dpram_fifo_ctrl #(
    parameter int ADDR_WIDTH    = 4,
    parameter int DATA_WIDTH    = 8,
    parameter int AFULL_THRESH  = 12,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] pop_data,
    output logic                  pop_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data
);

    localparam int PW    = ADDR_WIDTH + 1;
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [PW-1:0] AF_TH = PW'(AFULL_THRESH);
    localparam logic [PW-1:0] AE_TH = PW'(AEMPTY_THRESH);

    if (AEMPTY_THRESH < 0 || AEMPTY_THRESH >= AFULL_THRESH || AFULL_THRESH > DEPTH) begin : g_bad_params
        $error("dpram_fifo_ctrl: need 0 <= AEMPTY_THRESH < AFULL_THRESH <= DEPTH");
    end

    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic          pop_valid_q, pop_valid_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;
    logic          push_acc, pop_acc;

    // Flags come straight from the registered pointers; the extra MSB
    // distinguishes full from empty when the low bits match.
    assign full         = (wptr_q[ADDR_WIDTH] != rptr_q[ADDR_WIDTH]) &&
                          (wptr_q[ADDR_WIDTH-1:0] == rptr_q[ADDR_WIDTH-1:0]);
    assign empty        = (wptr_q == rptr_q);
    assign count        = wptr_q - rptr_q;
    assign almost_full  = (count >= AF_TH);
    assign almost_empty = (count <= AE_TH);

    // Gating with rst keeps the RAM idle while reset is held, since the reset
    // pointers alone would otherwise allow a push.
    assign push_acc = push & ~full  & ~clr & rst;
    assign pop_acc  = pop  & ~empty & ~clr & rst;

    assign wr_en    = push_acc;
    assign wr_addr  = wptr_q[ADDR_WIDTH-1:0];
    assign wr_data  = push_data;
    assign rd_en    = pop_acc;
    assign rd_addr  = rptr_q[ADDR_WIDTH-1:0];

    assign pop_data  = rd_data;
    assign pop_valid = pop_valid_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

    always_comb begin
        wptr_d      = wptr_q + PW'(push_acc);
        rptr_d      = rptr_q + PW'(pop_acc);
        pop_valid_d = pop_acc;
        ovf_d       = push & full  & ~clr;
        unf_d       = pop  & empty & ~clr;
        if (clr) begin
            wptr_d = '0;
            rptr_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            pop_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            pop_valid_q <= pop_valid_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
        end
    end

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
module tb_dpram_fifo_ctrl;

    logic       clk = 1'b0;
    logic       rst, clr, push, pop;
    logic [7:0] push_data, pop_data, wr_data, rd_data;
    logic       pop_valid, full, empty, almost_full, almost_empty;
    logic [4:0] count;
    logic       overflow, underflow, wr_en, rd_en;
    logic [3:0] wr_addr, rd_addr;

    always #5 clk = ~clk;

    dpram_fifo_ctrl dut (
        .clk(clk), .rst(rst), .clr(clr), .push(push), .push_data(push_data),
        .pop(pop), .pop_data(pop_data), .pop_valid(pop_valid), .full(full),
        .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
        .count(count), .overflow(overflow), .underflow(underflow),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data)
    );

    // External RAM: synchronous write, one-cycle registered read.
    logic [7:0] mem [16];
    always @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data <= mem[rd_addr];
    end

    int errs = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: FIFO contents as a queue, plus counts of accepted
    // writes/reads since the last flush to predict RAM addresses.
    logic [7:0] q[$];
    logic [7:0] exp_q[$];   // scoreboard: data expected on pop_data
    bit exp_pv, exp_ov, exp_un;
    int wcnt, rcnt;

    // Monitor: every presented pop_data is matched against the scoreboard.
    always @(negedge clk) begin
        if (rst === 1'b1 && pop_valid === 1'b1) begin
            if (exp_q.size() == 0) chk("pop_unexpected", 1, 0);
            else chk("pop_data", {24'd0, pop_data}, {24'd0, exp_q.pop_front()});
        end
    end

    task automatic step(input bit r, input bit p, input bit o, input bit c, input logic [7:0] d);
        int  n;
        bit  pa, oa;
        rst = r; push = p; pop = o; clr = c; push_data = d;
        @(negedge clk);
        if (!r) begin
            q.delete(); exp_q.delete();
            exp_pv = 0; exp_ov = 0; exp_un = 0; wcnt = 0; rcnt = 0;
        end
        n  = q.size();
        pa = r && p && n < 16 && !c;
        oa = r && o && n > 0 && !c;
        chk("count", {27'd0, count}, n);
        chk("full", full, n == 16);
        chk("empty", empty, n == 0);
        chk("almost_full", almost_full, n >= 12);
        chk("almost_empty", almost_empty, n <= 2);
        chk("wr_en", wr_en, pa);
        chk("rd_en", rd_en, oa);
        chk("pop_valid", pop_valid, exp_pv);
        chk("overflow", overflow, exp_ov);
        chk("underflow", underflow, exp_un);
        if (pa) begin
            chk("wr_addr", wr_addr, wcnt % 16);
            chk("wr_data", wr_data, d);
        end
        if (oa) chk("rd_addr", rd_addr, rcnt % 16);
        if (r) begin
            exp_ov = p && n == 16 && !c;
            exp_un = o && n == 0 && !c;
            exp_pv = oa;
            if (c) begin
                q.delete(); wcnt = 0; rcnt = 0;
            end else begin
                if (oa) begin exp_q.push_back(q.pop_front()); rcnt++; end
                if (pa) begin q.push_back(d); wcnt++; end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 0; clr = 0; push = 0; pop = 0; push_data = 0;
        // Reset with requests active, then release and idle
        step(0, 1, 1, 0, 8'hAA);
        step(0, 1, 1, 0, 8'hAB);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        // Fill, then one rejected push
        for (int i = 0; i < 17; i++) step(1, 1, 0, 0, 8'(i));
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        // Drain in order, then one rejected pop
        for (int i = 0; i < 17; i++) step(1, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        // Concurrent traffic at count 5
        for (int i = 0; i < 5; i++) step(1, 1, 0, 0, 8'(8'h20 + i));
        for (int i = 0; i < 10; i++) step(1, 1, 1, 0, 8'(8'h30 + i));
        for (int i = 0; i < 11; i++) step(1, 1, 0, 0, 8'(8'h40 + i));
        step(1, 1, 1, 0, 8'hEE);            // full: pop only, overflow
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 15; i++) step(1, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 1, 1, 0, 8'h55);            // empty: push only, underflow
        step(1, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0);
        // Wrap-around
        for (int i = 0; i < 40; i++) begin
            step(1, 1, 0, 0, 8'(8'h80 + i));
            step(1, 0, 1, 0, 0);
        end
        step(1, 0, 0, 0, 0);
        // Flush mid-stream, refill, reset right after a pop
        for (int i = 0; i < 9; i++) step(1, 1, 0, 0, 8'(8'hC0 + i));
        step(1, 1, 1, 1, 8'hFF);
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 8'(8'hD0 + i));
        step(1, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        // Random traffic
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 99) != 0), $urandom_range(0, 2) != 0,
                 $urandom_range(0, 2) != 0, $urandom_range(0, 39) == 0, 8'($urandom));
        end
        for (int i = 0; i < 20; i++) step(1, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
